// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter for the UART TX datapath.
// One word is accepted per valid/ready handshake together with its frame
// length; bits leave one per serializer_EN strobe, LSB- or MSB-first, and
// serial_done pulses for one cycle on the strobe that follows the last bit.
module piso_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter int   CNT_WIDTH  = 4,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LVL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] parallel_data,
    input  logic [CNT_WIDTH-1:0]  frame_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  serializer_EN,
    output logic                  serial_data,
    output logic                  busy,
    output logic                  serial_done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // A zero or oversize request means "send a full word".
    function automatic logic [CNT_WIDTH-1:0] clamp_len(input logic [CNT_WIDTH-1:0] len);
        logic [CNT_WIDTH-1:0] res;
        if ((len == {CNT_WIDTH{1'b0}}) || (len > CNT_WIDTH'(DATA_WIDTH))) begin
            res = CNT_WIDTH'(DATA_WIDTH);
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Bit multiplexer written as an OR-reduction so the index may be wider
    // than the data word needs without any out-of-range select.
    function automatic logic frame_bit(input logic [DATA_WIDTH-1:0] word,
                                       input logic [CNT_WIDTH-1:0]  sel);
        logic res;
        res = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            res = res | ((sel == CNT_WIDTH'(i)) & word[i]);
        end
        return res;
    endfunction

    state_t                state_r;
    state_t                next_state_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] next_data_s;
    logic [CNT_WIDTH-1:0]  len_r;
    logic [CNT_WIDTH-1:0]  next_len_s;
    logic [CNT_WIDTH-1:0]  index_r;
    logic [CNT_WIDTH-1:0]  next_index_s;
    logic [CNT_WIDTH-1:0]  sel_s;
    logic                  serial_r;
    logic                  next_serial_s;
    logic                  busy_r;
    logic                  next_busy_s;
    logic                  done_r;
    logic                  next_done_s;

    assign data_ready  = (state_r == ST_IDLE);
    assign serial_data = serial_r;
    assign busy        = busy_r;
    assign serial_done = done_r;

    // Word position of the frame bit at the current index, per bit order.
    always_comb begin
        if (MSB_FIRST) begin
            sel_s = len_r - index_r - CNT_WIDTH'(1);
        end else begin
            sel_s = index_r;
        end
    end

    // Next-state and next-output logic of the IDLE/SHIFT frame FSM.
    always_comb begin
        next_state_s  = state_r;
        next_data_s   = data_r;
        next_len_s    = len_r;
        next_index_s  = index_r;
        next_serial_s = serial_r;
        next_busy_s   = busy_r;
        next_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_serial_s = IDLE_LVL;
                next_busy_s   = 1'b0;
                if (data_valid) begin
                    next_data_s  = parallel_data;
                    next_len_s   = clamp_len(frame_len);
                    next_index_s = {CNT_WIDTH{1'b0}};
                    next_busy_s  = 1'b1;
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (serializer_EN) begin
                    if (index_r < len_r) begin
                        next_serial_s = frame_bit(data_r, sel_s);
                        next_index_s  = index_r + CNT_WIDTH'(1);
                    end else begin
                        // Strobe after the last bit closes the frame, so the
                        // last bit is held for a full strobe period.
                        next_serial_s = IDLE_LVL;
                        next_busy_s   = 1'b0;
                        next_done_s   = 1'b1;
                        next_state_s  = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            default: begin
                next_state_s  = ST_IDLE;
                next_serial_s = IDLE_LVL;
                next_busy_s   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            data_r   <= {DATA_WIDTH{1'b0}};
            len_r    <= {CNT_WIDTH{1'b0}};
            index_r  <= {CNT_WIDTH{1'b0}};
            serial_r <= IDLE_LVL;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            data_r   <= next_data_s;
            len_r    <= next_len_s;
            index_r  <= next_index_s;
            serial_r <= next_serial_s;
            busy_r   <= next_busy_s;
            done_r   <= next_done_s;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first and an MSB-first instance share
// the same stimulus. Each accepted word is expanded into its expected bit
// list plus an end-of-frame marker; a monitor pops one entry per strobe
// that the DUT shifts on and compares the serial outputs.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] parallel_data = 8'h00;
    logic [3:0] frame_len = 4'd0;
    logic       data_valid = 1'b0;
    logic       serializer_en = 1'b0;

    logic rdy0, ser0, busy0, done0;
    logic rdy1, ser1, busy1, done1;

    int total = 0;
    int bad = 0;
    int exp0[$];
    int exp1[$];
    int en_period = 1;
    int en_cnt = 0;
    logic en_q = 1'b0;
    logic bq0 = 1'b0;
    logic bq1 = 1'b0;

    piso_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_lsb (
        .clk(clk), .rst(rst_n), .parallel_data(parallel_data), .frame_len(frame_len),
        .data_valid(data_valid), .data_ready(rdy0), .serializer_EN(serializer_en),
        .serial_data(ser0), .busy(busy0), .serial_done(done0)
    );

    piso_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_msb (
        .clk(clk), .rst(rst_n), .parallel_data(parallel_data), .frame_len(frame_len),
        .data_valid(data_valid), .data_ready(rdy1), .serializer_EN(serializer_en),
        .serial_data(ser1), .busy(busy1), .serial_done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: frame = clamped length, bit i is data[i] (LSB) or data[n-1-i] (MSB).
    function automatic void push_frame(input logic [7:0] d, input logic [3:0] l);
        int n;
        n = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
        for (int i = 0; i < n; i++) begin
            exp0.push_back(int'((d >> i) & 8'd1));
            exp1.push_back(int'((d >> (n - 1 - i)) & 8'd1));
        end
        exp0.push_back(2);
        exp1.push_back(2);
    endfunction

    // Strobe generator: every en_period-th cycle, or random when en_period is 0.
    always @(posedge clk) begin
        #1;
        if (en_period == 0) begin
            serializer_en = 1'($urandom_range(0, 1));
        end else begin
            en_cnt = (en_cnt + 1) % en_period;
            serializer_en = (en_cnt == 0);
        end
    end

    // Capture the pre-edge strobe and busy flags that qualify a shift event.
    always @(posedge clk) begin
        en_q = serializer_en;
        bq0 = busy0;
        bq1 = busy1;
    end

    task automatic mon_one(input string tag, input int item, input logic s, input logic b,
                           input logic d, input logic r);
        if (item < 0) begin
            total++;
            bad++;
            $display("FAIL %s_extra_event: got shift event, expected none at %0t", tag, $time);
        end else if (item == 2) begin
            check({tag, "_end_serial"}, s, 1);
            check({tag, "_end_done"}, d, 1);
            check({tag, "_end_busy"}, b, 0);
            check({tag, "_end_ready"}, r, 1);
        end else begin
            check({tag, "_bit"}, s, item);
            check({tag, "_bit_done"}, d, 0);
            check({tag, "_bit_busy"}, b, 1);
            check({tag, "_bit_ready"}, r, 0);
        end
    endtask

    // Monitor: pops one expected entry per shift event, else requires done low.
    always @(negedge clk) begin
        int item;
        if (rst_n) begin
            if (en_q && bq0) begin
                if (exp0.size() > 0) item = exp0.pop_front(); else item = -1;
                mon_one("lsb", item, ser0, busy0, done0, rdy0);
            end else begin
                check("lsb_done_quiet", done0, 0);
            end
            if (en_q && bq1) begin
                if (exp1.size() > 0) item = exp1.pop_front(); else item = -1;
                mon_one("msb", item, ser1, busy1, done1, rdy1);
            end else begin
                check("msb_done_quiet", done1, 0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] l, input bit hold);
        bit ok;
        ok = 1'b0;
        parallel_data = d;
        frame_len = l;
        data_valid = 1'b1;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(posedge clk);
            if (rdy0 === 1'b1) ok = 1'b1;
        end
        check("handshake", 32'(ok), 1);
        if (ok) push_frame(d, l);
        #1;
        if (!hold) data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (((exp0.size() != 0) || (exp1.size() != 0)) && (c < 1000)) begin
            @(negedge clk);
            c++;
        end
        check("drain", 32'(exp0.size() + exp1.size()), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_serial_lsb"}, ser0, 1);
        check({tag, "_serial_msb"}, ser1, 1);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_ready"}, rdy0, 1);
        check({tag, "_done"}, done0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold;
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset");
        check("reset_busy_msb", busy1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle with the strobe toggling: nothing happens.
        en_period = 0;
        repeat (20) begin
            @(negedge clk);
            check_idle("idle");
        end

        // LSB/MSB frames with several strobe cadences.
        en_period = 1;
        send(8'hA5, 4'd8, 1'b0);
        wait_idle();
        en_period = 4;
        send(8'h13, 4'd5, 1'b0);
        wait_idle();

        // Zero and oversize lengths clamp to a full word.
        en_period = 1;
        send(8'h00, 4'd0, 1'b0);
        wait_idle();
        send(8'h00, 4'd12, 1'b0);
        wait_idle();

        // Valid held high: second word loads only after the first completes.
        en_period = 2;
        send(8'h3C, 4'd8, 1'b1);
        send(8'hFF, 4'd8, 1'b0);
        wait_idle();

        // Reset after the third bit drops the frame with no done pulse.
        en_period = 1;
        send(8'hC6, 4'd8, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle("midreset");
        check("midreset_busy_msb", busy1, 0);
        exp0.delete();
        exp1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h81, 4'd8, 1'b0);
        wait_idle();

        // Randomized frames, lengths, cadences and back-to-back loads.
        repeat (40) begin
            en_period = $urandom_range(0, 3);
            hold = 1'($urandom_range(0, 1));
            send(8'($urandom), 4'($urandom), hold);
            if (!hold) wait_idle();
        end
        data_valid = 1'b0;
        en_period = 1;
        wait_idle();
        repeat (5) begin
            @(negedge clk);
            check_idle("final");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
